txn_sequencer: RTL

- Top-level transaction sequencer for the coin-game datapath; successor to the fixed two-field controller.
- Runs a power-up init phase, then loops: display balances, load NUM_FIELDS operands by button press/release, arm, run the transaction, then pulse a timed reset to the datapath.
- Adds abort, a transaction timeout with sticky error, a transaction counter, and a parametrised cleanup pulse length.

---
 rtl/txn_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/txn_sequencer.sv
// Coin-game transaction sequencer: power-up init, operand load by press/release, armed run, timed datapath reset.
// Moore outputs from registered state (one-cycle decision latency); buttons are levels, abort wins in LOAD/GAP/ARMED.
module txn_sequencer #(
  parameter int NUM_FIELDS     = 2,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load_signal,
  input  logic                  start_signal,
  input  logic                  abort,
  input  logic                  done_table_init,
  input  logic                  finished_init,
  input  logic                  finished_transaction,
  output logic                  global_reset_n,
  output logic                  random_init,
  output logic                  init_memory,
  output logic                  load_memory,
  output logic [NUM_FIELDS-1:0] load_field,
  output logic                  start_transaction,
  output logic                  reset_others_n,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int FW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] LAST_FIELD = FW'(NUM_FIELDS - 1);
  localparam logic [TW-1:0] TMAX       = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [7:0]    RMAX       = 8'(RESET_CYCLES - 1);

  typedef enum logic [3:0] {
    S_STARTUP    = 4'd0,
    S_INIT_TABLE = 4'd1,
    S_INIT_MEM   = 4'd2,
    S_CLEANUP    = 4'd3,
    S_IDLE       = 4'd4,
    S_LOAD       = 4'd5,
    S_GAP        = 4'd6,
    S_ARMED      = 4'd7,
    S_TXN        = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    field_idx_q, field_idx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_STARTUP;
      field_idx_q <= '0;
      tcnt_q      <= '0;
      rcnt_q      <= '0;
      terr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      field_idx_q <= field_idx_d;
      tcnt_q      <= tcnt_d;
      rcnt_q      <= rcnt_d;
      terr_q      <= terr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Both cycle counters idle at zero outside their own state, so entry always starts a fresh count.
  always_comb begin
    state_d     = state_q;
    field_idx_d = field_idx_q;
    tcnt_d      = '0;
    rcnt_d      = '0;
    terr_d      = terr_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_STARTUP:    state_d = S_INIT_TABLE;
      S_INIT_TABLE: if (done_table_init) state_d = S_INIT_MEM;
      S_INIT_MEM:   if (finished_init) state_d = S_CLEANUP;
      S_CLEANUP: begin
        if (rcnt_q == RMAX) state_d = S_IDLE;
        else                rcnt_d  = rcnt_q + 8'd1;
      end
      S_IDLE: begin
        if (load_signal) begin
          state_d     = S_LOAD;
          field_idx_d = '0;
          terr_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort)                           state_d = S_CLEANUP;
        else if (!load_signal)               state_d = (field_idx_q == LAST_FIELD) ? S_ARMED : S_GAP;
      end
      S_GAP: begin
        if (abort) state_d = S_CLEANUP;
        else if (load_signal) begin
          state_d     = S_LOAD;
          field_idx_d = field_idx_q + FW'(1);
        end
      end
      S_ARMED: begin
        if (abort)             state_d = S_CLEANUP;
        else if (start_signal) state_d = S_TXN;
      end
      S_TXN: begin
        if (finished_transaction) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_CLEANUP;
        end else if ((TIMEOUT_CYCLES > 0) && (tcnt_q == TMAX)) begin
          terr_d  = 1'b1;
          state_d = S_CLEANUP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_STARTUP;
    endcase
  end

  always_comb begin
    global_reset_n    = 1'b1;
    random_init       = 1'b0;
    init_memory       = 1'b0;
    load_memory       = 1'b0;
    load_field        = '0;
    start_transaction = 1'b0;
    reset_others_n    = 1'b1;
    busy              = (state_q != S_IDLE);
    timeout_err       = terr_q;
    txn_count         = cnt_q;
    case (state_q)
      S_STARTUP:    global_reset_n    = 1'b0;
      S_INIT_TABLE: random_init       = 1'b1;
      S_INIT_MEM:   init_memory       = 1'b1;
      S_CLEANUP:    reset_others_n    = 1'b0;
      S_IDLE:       load_memory       = 1'b1;
      S_TXN:        start_transaction = 1'b1;
      S_LOAD: begin
        for (int i = 0; i < NUM_FIELDS; i++) load_field[i] = (field_idx_q == FW'(i));
      end
      default: ;
    endcase
  end

endmodule
